// File: rtl/arc4_param.sv
// ARC4 decrypt core with configurable key length and RC4-dropN discard.
// It decrypts a length-prefixed message from CT memory into PT memory and reports whether the plaintext is printable.
module arc4_param #(
    parameter int KEY_BYTES = 3,
    parameter int DROP_N    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren,
    output logic                   pt_ok
);

    localparam int KW  = 8 * KEY_BYTES;
    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIW-1:0] KIDX_LAST = KIW'(KEY_BYTES - 1);
    localparam logic [9:0]     DROP_LAST = (DROP_N > 0) ? 10'(DROP_N - 1) : 10'd0;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_KSA, S_RLEN0, S_RLEN1, S_DROP, S_PRGA_A, S_PRGA_B, S_WRLEN
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_s [256];
    logic [KW-1:0]   r_key;
    logic [7:0]      r_len;
    logic [7:0]      r_i, r_j, r_k;
    logic [9:0]      r_cnt;
    logic [KIW-1:0]  r_kidx;
    logic            r_ok, r_pt_ok;
    logic [7:0]      r_ct_addr, r_pt_addr, r_pt_wrdata;

    logic [7:0]      w_kb [KEY_BYTES];
    logic [7:0]      w_keybyte, w_sw_i, w_sw_j, w_si, w_sj, w_pidx, w_pad;
    logic            w_swap, w_bad;
    logic [7:0]      w_ct_addr, w_pt_addr, w_pt_wrdata;
    logic            w_pt_wren;

    always_comb begin
        for (int n = 0; n < KEY_BYTES; n++) begin
            w_kb[n] = r_key[KW-1-8*n -: 8];
        end
    end

    // KSA and PRGA share one swap path; only the i source and the key term differ
    assign w_keybyte = w_kb[r_kidx];
    assign w_swap    = (r_state == S_KSA) || (r_state == S_DROP) || (r_state == S_PRGA_A);
    assign w_sw_i    = (r_state == S_KSA) ? r_i : r_i + 8'd1;
    assign w_si      = r_s[w_sw_i];
    assign w_sw_j    = r_j + w_si + ((r_state == S_KSA) ? w_keybyte : 8'd0);
    assign w_sj      = r_s[w_sw_j];
    assign w_pidx    = r_s[r_i] + r_s[r_j];
    assign w_pad     = r_s[w_pidx];
    assign w_bad     = (w_pt_wrdata < 8'h20) || (w_pt_wrdata > 8'h7E);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_ct_addr   = r_ct_addr;
        w_pt_addr   = r_pt_addr;
        w_pt_wrdata = r_pt_wrdata;
        w_pt_wren   = 1'b0;
        case (r_state)
            S_IDLE:   if (en) w_next = S_INIT;
            S_INIT:   if (r_i == 8'hFF) w_next = S_KSA;
            S_KSA:    if (r_i == 8'hFF) w_next = S_RLEN0;
            S_RLEN0: begin
                w_ct_addr = 8'd0;
                w_next    = S_RLEN1;
            end
            S_RLEN1: begin
                w_ct_addr = 8'd0;
                if (DROP_N > 0)             w_next = S_DROP;
                else if (ct_rddata == 8'd0) w_next = S_WRLEN;
                else                        w_next = S_PRGA_A;
            end
            S_DROP:   if (r_cnt == DROP_LAST) w_next = (r_len == 8'd0) ? S_WRLEN : S_PRGA_A;
            S_PRGA_A: begin
                w_ct_addr = r_k;
                w_next    = S_PRGA_B;
            end
            S_PRGA_B: begin
                w_pt_addr   = r_k;
                w_pt_wrdata = w_pad ^ ct_rddata;
                w_pt_wren   = 1'b1;
                w_next      = (r_k == r_len) ? S_WRLEN : S_PRGA_A;
            end
            S_WRLEN: begin
                w_pt_addr   = 8'd0;
                w_pt_wrdata = r_len;
                w_pt_wren   = 1'b1;
                w_next      = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i         <= 8'd0;
            r_j         <= 8'd0;
            r_k         <= 8'd0;
            r_cnt       <= 10'd0;
            r_kidx      <= '0;
            r_ok        <= 1'b0;
            r_pt_ok     <= 1'b0;
            r_ct_addr   <= 8'd0;
            r_pt_addr   <= 8'd0;
            r_pt_wrdata <= 8'd0;
        end else begin
            r_ct_addr   <= w_ct_addr;
            r_pt_addr   <= w_pt_addr;
            r_pt_wrdata <= w_pt_wrdata;
            case (r_state)
                S_IDLE: if (en) begin
                    r_i     <= 8'd0;
                    r_j     <= 8'd0;
                    r_kidx  <= '0;
                    r_ok    <= 1'b1;
                    r_pt_ok <= 1'b0;
                end
                S_INIT: r_i <= r_i + 8'd1;
                S_KSA: begin
                    r_i    <= r_i + 8'd1;
                    r_j    <= w_sw_j;
                    r_kidx <= (r_kidx == KIDX_LAST) ? '0 : r_kidx + 1'b1;
                end
                S_RLEN1: begin
                    r_i   <= 8'd0;
                    r_j   <= 8'd0;
                    r_k   <= 8'd1;
                    r_cnt <= 10'd0;
                end
                S_DROP: begin
                    r_i   <= w_sw_i;
                    r_j   <= w_sw_j;
                    r_cnt <= r_cnt + 10'd1;
                end
                S_PRGA_A: begin
                    r_i <= w_sw_i;
                    r_j <= w_sw_j;
                end
                S_PRGA_B: begin
                    r_k <= r_k + 8'd1;
                    if (w_bad) r_ok <= 1'b0;
                end
                S_WRLEN: r_pt_ok <= r_ok;
                default: ;
            endcase
        end
    end

    // S, the latched key and L are pure data and carry no reset
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && en) r_key <= key;
        if (r_state == S_RLEN1)      r_len <= ct_rddata;
        if (r_state == S_INIT) begin
            r_s[r_i] <= r_i;
        end else if (w_swap) begin
            r_s[w_sw_i] <= w_sj;
            r_s[w_sw_j] <= w_si;
        end
    end

    assign rdy       = (r_state == S_IDLE);
    assign ct_addr   = w_ct_addr;
    assign pt_addr   = w_pt_addr;
    assign pt_wrdata = w_pt_wrdata;
    assign pt_wren   = w_pt_wren;
    assign pt_ok     = r_pt_ok;

endmodule

// File: tb/tb_arc4_param.sv
// Directed bench for arc4_param: three instances cover 3-byte and 5-byte keys, with and without a 768-byte keystream drop.
// A small RC4 model and RFC 6229 constants supply the expected plaintext.
module tb_arc4_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr;
    logic [7:0] ct_mem [256];

    logic        en0, rdy0, wren0, ok0;
    logic [23:0] key0;
    logic [7:0]  cta0, ctd0, pta0, ptd0;
    logic        en1, rdy1, wren1, ok1;
    logic [39:0] key1;
    logic [7:0]  cta1, ctd1, pta1, ptd1;
    logic        en2, rdy2, wren2, ok2;
    logic [39:0] key2;
    logic [7:0]  cta2, ctd2, pta2, ptd2;

    arc4_param #(.KEY_BYTES(3), .DROP_N(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .rdy(rdy0), .key(key0),
        .ct_addr(cta0), .ct_rddata(ctd0), .pt_addr(pta0), .pt_wrdata(ptd0),
        .pt_wren(wren0), .pt_ok(ok0));
    arc4_param #(.KEY_BYTES(5), .DROP_N(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .rdy(rdy1), .key(key1),
        .ct_addr(cta1), .ct_rddata(ctd1), .pt_addr(pta1), .pt_wrdata(ptd1),
        .pt_wren(wren1), .pt_ok(ok1));
    arc4_param #(.KEY_BYTES(5), .DROP_N(768)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .rdy(rdy2), .key(key2),
        .ct_addr(cta2), .ct_rddata(ctd2), .pt_addr(pta2), .pt_wrdata(ptd2),
        .pt_wren(wren2), .pt_ok(ok2));

    logic [7:0]   pt0 [256];
    logic [7:0]   pt1 [256];
    logic [7:0]   pt2 [256];
    int           wc0, wc1, wc2;
    logic [255:0] seen0;

    always @(posedge clk) ctd0 <= ct_mem[cta0];
    always @(posedge clk) ctd1 <= ct_mem[cta1];
    always @(posedge clk) ctd2 <= ct_mem[cta2];

    always @(posedge clk) begin
        if (clr) begin
            wc0 <= 0; seen0 <= '0;
        end else if (wren0) begin
            pt0[pta0] <= ptd0; wc0 <= wc0 + 1; seen0[pta0] <= 1'b1;
        end
    end
    always @(posedge clk) begin
        if (clr) wc1 <= 0;
        else if (wren1) begin pt1[pta1] <= ptd1; wc1 <= wc1 + 1; end
    end
    always @(posedge clk) begin
        if (clr) wc2 <= 0;
        else if (wren2) begin pt2[pta2] <= ptd2; wc2 <= wc2 + 1; end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic get_rdy(input int sel);
        case (sel) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
    endfunction
    function automatic logic get_ok(input int sel);
        case (sel) 0: return ok0; 1: return ok1; default: return ok2; endcase
    endfunction
    function automatic logic [7:0] get_pt(input int sel, input int a);
        case (sel) 0: return pt0[8'(a)]; 1: return pt1[8'(a)]; default: return pt2[8'(a)]; endcase
    endfunction
    function automatic int get_wc(input int sel);
        case (sel) 0: return wc0; 1: return wc1; default: return wc2; endcase
    endfunction

    // RFC 6229, key 0x0102030405, keystream offset 0
    logic [7:0] rfc [16] = '{8'hb2, 8'h39, 8'h63, 8'h05, 8'hf0, 8'h3d, 8'hc0, 8'h27,
                             8'hcc, 8'hc3, 8'h52, 8'h4a, 8'h0a, 8'h11, 8'h18, 8'ha8};
    logic [7:0] ks     [256];
    logic [7:0] exp_pt [256];

    task automatic rc4_model(input logic [39:0] k, input int klen, input int drop, input int n);
        int s [256];
        int i, j, t;
        logic [7:0] kb;
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            kb = k[8*(klen-1-(a % klen)) +: 8];
            j = (j + s[a] + int'(kb)) & 255;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int m = 0; m < drop + n; m++) begin
            i = (i + 1) & 255;
            j = (j + s[i]) & 255;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (m >= drop) ks[m-drop+1] = 8'(s[(s[i] + s[j]) & 255]);
        end
    endtask

    // mode 0: CT encrypts a printable message; mode 1: CT is all zero so PT is raw keystream
    task automatic prep(input int sel, input logic [39:0] k, input int len, input int mode, input int seed);
        rc4_model(k, (sel == 0) ? 3 : 5, (sel == 2) ? 768 : 0, len);
        ct_mem[0] = 8'(len);
        exp_pt[0] = 8'(len);
        for (int kk = 1; kk <= len; kk++) begin
            if (mode == 0) begin
                exp_pt[kk] = 8'h20 + 8'((kk * 7 + seed) % 95);
                ct_mem[kk] = exp_pt[kk] ^ ks[kk];
            end else begin
                ct_mem[kk] = 8'h00;
                exp_pt[kk] = (sel == 1) ? rfc[kk-1] : ks[kk];
            end
        end
    endtask

    task automatic clear_pt();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic run(input int sel, input logic [39:0] k, output int cyc, output logic okv);
        clear_pt();
        case (sel)
            0: begin key0 = k[23:0]; en0 = 1'b1; end
            1: begin key1 = k; en1 = 1'b1; end
            default: begin key2 = k; en2 = 1'b1; end
        endcase
        @(negedge clk);
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        cyc = 0;
        while (get_rdy(sel) == 1'b0 && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        okv = get_ok(sel);
    endtask

    task automatic check_pt(input string nm, input int sel, input int len);
        for (int a = 0; a <= len; a++) chk($sformatf("%s_pt[%0d]", nm, a), 64'(get_pt(sel, a)), 64'(exp_pt[a]));
    endtask

    typedef struct {
        int          sel;
        logic [39:0] key;
        int          len;
        int          mode;
        int          seed;
        int          exp_ok;   // 2 = derive from expected plaintext
        int          exp_cyc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int   cyc;
        logic okv, okd, ok_a;

        vecs[0] = '{0, 40'h0000000018,  53, 0, 11, 1,  621};
        vecs[1] = '{1, 40'h0102030405,  16, 1,  0, 0,  547};
        vecs[2] = '{2, 40'h0102030405,  16, 1,  0, 2, 1315};
        vecs[3] = '{0, 40'h0000000018,   0, 0,  5, 1,  515};
        vecs[4] = '{0, 40'h0000abcdef, 255, 0, 29, 1, 1025};

        rst_n = 1'b0; clr = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        key0 = '0; key1 = '0; key2 = '0;
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rdy",    64'(rdy0),  64'd1);
        chk("rst_wren",   64'(wren0), 64'd0);
        chk("rst_ctaddr", 64'(cta0),  64'd0);
        chk("rst_ptaddr", 64'(pta0),  64'd0);
        chk("rst_ptdata", 64'(ptd0),  64'd0);
        chk("rst_ptok",   64'(ok0),   64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            prep(vecs[v].sel, vecs[v].key, vecs[v].len, vecs[v].mode, vecs[v].seed);
            okd = 1'b1;
            for (int a = 1; a <= vecs[v].len; a++)
                if (exp_pt[a] < 8'h20 || exp_pt[a] > 8'h7E) okd = 1'b0;
            run(vecs[v].sel, vecs[v].key, cyc, okv);
            chk($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].exp_cyc));
            chk($sformatf("v%0d_ptok", v), 64'(okv), (vecs[v].exp_ok == 2) ? 64'(okd) : 64'(vecs[v].exp_ok));
            check_pt($sformatf("v%0d", v), vecs[v].sel, vecs[v].len);
            chk($sformatf("v%0d_writes", v), 64'(get_wc(vecs[v].sel)), 64'(vecs[v].len + 1));
            if (vecs[v].len == 255) chk("v4_all_addr", 64'(&seen0), 64'd1);
        end

        // reset pulse during PRGA byte 10, then a clean rerun of the first message
        prep(0, 40'h18, 53, 0, 11);
        clear_pt();
        key0 = 24'h000018; en0 = 1'b1;
        @(negedge clk); en0 = 1'b0;
        cyc = 0;
        while (wc0 < 9 && cyc < 3000) begin cyc++; @(negedge clk); end
        chk("rst_mid_reached", 64'(wc0), 64'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy",  64'(rdy0),  64'd1);
        chk("rst_mid_wren", 64'(wren0), 64'd0);
        chk("rst_mid_ok",   64'(ok0),   64'd0);
        chk("rst_mid_cta",  64'(cta0),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_nowrite", 64'(wc0), 64'd9);
        run(0, 40'h18, cyc, okv);
        chk("rerun_cycles", 64'(cyc), 64'd621);
        chk("rerun_ptok",   64'(okv), 64'd1);
        check_pt("rerun", 0, 53);

        // en held across two runs, key changed and en toggled while busy
        prep(0, 40'h123456, 8, 0, 41);
        rc4_model(40'h18, 3, 0, 8);
        ok_a = 1'b1;
        for (int a = 1; a <= 8; a++)
            if ((ct_mem[a] ^ ks[a]) < 8'h20 || (ct_mem[a] ^ ks[a]) > 8'h7E) ok_a = 1'b0;
        clear_pt();
        key0 = 24'h000018; en0 = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (rdy0 == 1'b0 && cyc < 5000) begin
            cyc++;
            if (cyc == 10) key0 = 24'h123456;
            if (cyc == 20) en0 = 1'b0;
            if (cyc == 25) en0 = 1'b1;
            @(negedge clk);
        end
        chk("b2b_run1_cycles", 64'(cyc), 64'd531);
        chk("b2b_run1_ptok",   64'(ok0), 64'(ok_a));
        @(negedge clk);
        cyc = 0;
        while (rdy0 == 1'b0 && cyc < 5000) begin cyc++; @(negedge clk); end
        en0 = 1'b0;
        chk("b2b_run2_cycles", 64'(cyc), 64'd531);
        chk("b2b_run2_ptok",   64'(ok0), 64'd1);
        chk("b2b_writes",      64'(wc0), 64'd18);
        check_pt("b2b", 0, 8);
        repeat (2) @(negedge clk);
        chk("b2b_idle", 64'(rdy0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arc4_param.md
Name: arc4_param

Overview:
Parametrised successor to the fixed 24-bit-key ARC4 decrypt core, and a drop-in replacement for it. Decrypts a length-prefixed ciphertext from CT memory into PT memory. Adds three things: configurable key length, RC4-dropN keystream discard, and a printable-plaintext verdict (pt_ok) for use by the key-search cracking loop.

Parameters:
KEY_BYTES, 3, key length in bytes (1..32); key port width is 8*KEY_BYTES.
DROP_N, 0, keystream bytes generated and discarded before the first one is used (0..1023).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  start request; sampled only while rdy=1
rdy  out  1  high when idle and able to accept en
key  in  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first); latched at start
ct_addr  out  8  CT memory read address
ct_rddata  in  8  CT read data; synchronous memory, valid one cycle after ct_addr
pt_addr  out  8  PT memory address
pt_wrdata  out  8  PT write data
pt_wren  out  1  PT write strobe, one cycle per byte
pt_ok  out  1  high when every plaintext byte of the last message is in 0x20..0x7E

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low via rst_n.
- Reset values (async, any state): rdy=1, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0, pt_ok=0, state=IDLE, i=j=k=0.
- Reset mid-operation: the core returns to IDLE immediately. PT contents are undefined. No further writes.
- S is an internal 256x8 register array, not exported.
- Handshake: en=1 with rdy=1 at an edge starts the operation.
  - key is latched on that edge; rdy drops on that edge.
  - en while rdy=0 is ignored.
  - en held high after completion starts a new run on the first edge with rdy=1.
- pt_ok is cleared at start. It is valid and stable from rdy rising until the next start.
- States and cycle counts:
  - IDLE: wait for en.
  - INIT: 256 cycles, S[n]=n for n=0..255.
  - KSA: 256 cycles, one per i=0..255. j=(j+S[i]+keybyte[i mod KEY_BYTES]) mod 256, then swap S[i],S[j]. Writes take effect at end of cycle.
  - READ_LEN: 2 cycles. ct_addr=0; L=ct_rddata is captured on the 2nd cycle. i and j are reset to 0.
  - DROP: DROP_N cycles, one PRGA step each, no write. State is skipped when DROP_N=0.
  - PRGA: 2 cycles per byte, k=1..L.
    - Cycle A: ct_addr=k; i=i+1; j=j+S[i]; swap S[i],S[j].
    - Cycle B: pad=S[(S[i]+S[j]) mod 256] using post-swap S; pt_addr=k; pt_wrdata=pad^ct_rddata; pt_wren=1.
    - If pt_wrdata is outside 0x20..0x7E, the internal ok flag clears.
    - State is skipped when L=0.
  - WRITE_LEN: 1 cycle. pt_addr=0; pt_wrdata=L; pt_wren=1.
  - Then IDLE with rdy=1 and pt_ok=ok flag.
- rdy is low for exactly 515+DROP_N+2L cycles.
- All index arithmetic is mod 256 (8-bit wrap). The keybyte index wraps mod KEY_BYTES.
- L=255 writes PT[1..255] plus PT[0]; no address overflow. L=0 writes only PT[0]=0 and gives pt_ok=1.
- pt_wren is never high outside PRGA cycle B and WRITE_LEN. ct_addr and pt_addr hold their last value otherwise.
- The PT length byte is exempt from the printable check.

Test Plan:
1. KEY_BYTES=3, DROP_N=0, key=0x000018, CT[0]=0x35 with 53 ciphertext bytes -> PT matches the software RC4 model byte for byte, PT[0]=0x35, pt_ok=1, rdy low exactly 515+106 cycles.
2. KEY_BYTES=5, key=0x0102030405, CT[0]=0x10, CT[1..16]=0x00 -> PT[1..8]=b2 39 63 05 f0 3d c0 27 and PT[9..16]=cc c3 52 4a 0a 11 18 a8 (RFC 6229, offset 0); pt_ok=0.
3. DROP_N=768, same key/CT as scenario 2 -> PT[1..16] equals RFC 6229 keystream at offset 768; rdy low 515+768+32 cycles.
4. CT[0]=0x00 -> exactly one write (PT[0]=0x00), pt_ok=1, rdy low 515 cycles. Then CT[0]=0xFF -> 256 writes, no write at an address >255.
5. Pulse rst_n low during PRGA byte 10 -> rdy=1 and pt_wren=0 immediately. A new en then completes correctly, matching the scenario 1 result.
6. en held high throughout two back-to-back runs with a different key on the second, and en toggled while busy -> the busy toggles have no effect. Second run uses the key latched at its own start; pt_ok reflects the second message only.
